// File: rtl/neo_sndlatch.sv
// neo_sndlatch: 68k<->Z80 sound command/reply mailbox with Z80 NMI generation.
// Define SNDLATCH_OVERRUN_EN to enable sticky command overrun detection.

module neo_sndlatch_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_n};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign fall = prev_q & ~sync_q[STAGES-1];
endmodule

module neo_sndlatch #(
    parameter int SYNC_STAGES    = 2,
    parameter int NMI_MIN_CYCLES = 24
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       nSNDWR,
    input  logic       nSNDRD,
    input  logic [7:0] M68K_DATA,
    output logic [7:0] SND_REPLY,
    input  logic       nSDZ80R,
    input  logic       nSDZ80W,
    input  logic       nSDZ80CLR,
    input  logic       nNMIEN,
    input  logic       nNMIDIS,
    input  logic [7:0] SDD_IN,
    output logic [7:0] SDD_OUT,
    output logic       nZ80NMI,
    output logic       CMD_PENDING,
    output logic       REPLY_VALID,
    output logic       OVERRUN
);
    localparam logic [7:0] CNT_TERM = 8'(NMI_MIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT
    } nmi_state_e;

    logic [6:0] strobe_n;
    logic [6:0] fall;
    logic       wr_ev;
    logic       rd_ev;
    logic       z80r_ev;
    logic       z80w_ev;
    logic       clr_ev;
    logic       en_ev;
    logic       dis_ev;
    logic       unused_z80_rd;

    assign strobe_n = {nNMIDIS, nNMIEN, nSDZ80CLR, nSDZ80W,
                       nSDZ80R, nSNDRD, nSNDWR};

    for (genvar i = 0; i < 7; i++) begin : g_sync
        neo_sndlatch_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (CLK_24M),
            .rst     (RESET),
            .strobe_n(strobe_n[i]),
            .fall    (fall[i])
        );
    end

    assign wr_ev   = fall[0];
    assign rd_ev   = fall[1];
    assign z80r_ev = fall[2];
    assign z80w_ev = fall[3];
    assign clr_ev  = fall[4];
    assign en_ev   = fall[5];
    assign dis_ev  = fall[6];

    // Z80 reads see SDD_OUT directly; the event carries no state.
    assign unused_z80_rd = z80r_ev;

    logic [7:0] sdd_out_q;
    logic       cmd_pending_q;
    logic [7:0] reply_q;
    logic       reply_valid_q;
    logic       nmi_en_q;

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            sdd_out_q     <= 8'h00;
            cmd_pending_q <= 1'b0;
        end else if (wr_ev) begin
            sdd_out_q     <= M68K_DATA;
            cmd_pending_q <= 1'b1;
        end else if (clr_ev) begin
            cmd_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            reply_q       <= 8'h00;
            reply_valid_q <= 1'b0;
        end else if (z80w_ev) begin
            reply_q       <= SDD_IN;
            reply_valid_q <= 1'b1;
        end else if (rd_ev) begin
            reply_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            nmi_en_q <= 1'b0;
        end else if (dis_ev) begin
            nmi_en_q <= 1'b0;
        end else if (en_ev) begin
            nmi_en_q <= 1'b1;
        end
    end

`ifdef SNDLATCH_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            overrun_q <= 1'b0;
        end else if (wr_ev) begin
            if (cmd_pending_q) begin
                overrun_q <= 1'b1;
            end
        end else if (clr_ev) begin
            overrun_q <= 1'b0;
        end
    end

    assign OVERRUN = overrun_q;
`else
    assign OVERRUN = 1'b0;
`endif

    nmi_state_e state_q;
    nmi_state_e state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       nmi_n;

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A fresh write restarts the pulse; disable overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_PULSE: begin
                if (cnt_q == CNT_TERM) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (!cmd_pending_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (wr_ev && nmi_en_q) begin
            state_d = ST_PULSE;
            cnt_d   = 8'h00;
        end
        if (dis_ev) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        nmi_n = 1'b1;
        unique case (state_q)
            ST_PULSE: nmi_n = 1'b0;
            ST_WAIT:  nmi_n = 1'b0;
            default:  nmi_n = 1'b1;
        endcase
    end

    assign SDD_OUT     = sdd_out_q;
    assign CMD_PENDING = cmd_pending_q;
    assign SND_REPLY   = reply_q;
    assign REPLY_VALID = reply_valid_q;
    assign nZ80NMI     = nmi_n;
endmodule

// File: tb/tb_neo_sndlatch.sv
// tb_neo_sndlatch: directed and randomized checks of neo_sndlatch
// against a time-based behavioural model of the mailbox.

module tb_neo_sndlatch;
    localparam int INF = 32'h7fff_ffff;
    localparam int NMI_LOW = 24;
    localparam int LAT = 3;

    localparam logic [6:0] M_WR  = 7'b0000001;
    localparam logic [6:0] M_RD  = 7'b0000010;
    localparam logic [6:0] M_ZR  = 7'b0000100;
    localparam logic [6:0] M_ZW  = 7'b0001000;
    localparam logic [6:0] M_CLR = 7'b0010000;
    localparam logic [6:0] M_EN  = 7'b0100000;
    localparam logic [6:0] M_DIS = 7'b1000000;

`ifdef SNDLATCH_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nSNDWR = 1'b1;
    logic       nSNDRD = 1'b1;
    logic [7:0] M68K_DATA = 8'h00;
    logic [7:0] SND_REPLY;
    logic       nSDZ80R = 1'b1;
    logic       nSDZ80W = 1'b1;
    logic       nSDZ80CLR = 1'b1;
    logic       nNMIEN = 1'b1;
    logic       nNMIDIS = 1'b1;
    logic [7:0] SDD_IN = 8'h00;
    logic [7:0] SDD_OUT;
    logic       nZ80NMI;
    logic       CMD_PENDING;
    logic       REPLY_VALID;
    logic       OVERRUN;

    neo_sndlatch dut (
        .CLK_24M    (clk),
        .RESET      (rst),
        .nSNDWR     (nSNDWR),
        .nSNDRD     (nSNDRD),
        .M68K_DATA  (M68K_DATA),
        .SND_REPLY  (SND_REPLY),
        .nSDZ80R    (nSDZ80R),
        .nSDZ80W    (nSDZ80W),
        .nSDZ80CLR  (nSDZ80CLR),
        .nNMIEN     (nNMIEN),
        .nNMIDIS    (nNMIDIS),
        .SDD_IN     (SDD_IN),
        .SDD_OUT    (SDD_OUT),
        .nZ80NMI    (nZ80NMI),
        .CMD_PENDING(CMD_PENDING),
        .REPLY_VALID(REPLY_VALID),
        .OVERRUN    (OVERRUN)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_cmd;
    logic       m_pend;
    logic [7:0] m_reply;
    logic       m_valid;
    logic       m_ovr;
    logic       m_en;
    logic       m_nmi_on;
    int         m_nmi_s;
    int         m_pend_fall;

    // NMI is low from the write edge for NMI_LOW cycles plus one WAIT
    // cycle, and until one cycle after the command was cleared.
    function automatic logic nmi_exp(input int t);
        if (!m_nmi_on || t < m_nmi_s) return 1'b1;
        if (t >= m_nmi_s + NMI_LOW + 1 &&
            m_pend_fall != INF && t >= m_pend_fall + 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_cmd = 8'h00;
        m_pend = 1'b0;
        m_reply = 8'h00;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_en = 1'b0;
        m_nmi_on = 1'b0;
        m_nmi_s = 0;
        m_pend_fall = INF;
    endtask

    task automatic model_apply(input logic [6:0] m, input int e);
        logic wr, rd, zw, clr, en, dis;
        wr = m[0]; rd = m[1]; zw = m[3];
        clr = m[4]; en = m[5]; dis = m[6];
        if (OVR_EN) begin
            if (wr && m_pend) m_ovr = 1'b1;
            else if (clr && !wr) m_ovr = 1'b0;
        end
        if (wr && m_en) begin
            m_nmi_on = 1'b1;
            m_nmi_s = e;
            m_pend_fall = INF;
        end
        if (wr) begin
            m_cmd = M68K_DATA;
            m_pend = 1'b1;
        end else if (clr) begin
            if (m_pend) m_pend_fall = e;
            m_pend = 1'b0;
        end
        if (dis) m_nmi_on = 1'b0;
        if (dis) m_en = 1'b0;
        else if (en) m_en = 1'b1;
        if (zw) begin
            m_reply = SDD_IN;
            m_valid = 1'b1;
        end else if (rd) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sdd_out"}, SDD_OUT, m_cmd);
        chk({tag, ".pending"}, {7'b0, CMD_PENDING}, {7'b0, m_pend});
        chk({tag, ".reply"}, SND_REPLY, m_reply);
        chk({tag, ".valid"}, {7'b0, REPLY_VALID}, {7'b0, m_valid});
        chk({tag, ".overrun"}, {7'b0, OVERRUN}, {7'b0, m_ovr});
        chk({tag, ".nmi"}, {7'b0, nZ80NMI}, {7'b0, nmi_exp(cyc)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk();
        tick();
        chk("nmi", {7'b0, nZ80NMI}, {7'b0, nmi_exp(cyc)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_chk();
    endtask

    task automatic drive(input logic [6:0] m);
        nSNDWR    = ~m[0];
        nSNDRD    = ~m[1];
        nSDZ80R   = ~m[2];
        nSDZ80W   = ~m[3];
        nSDZ80CLR = ~m[4];
        nNMIEN    = ~m[5];
        nNMIDIS   = ~m[6];
    endtask

    task automatic strobe(input string tag, input logic [6:0] m,
                          input logic [7:0] wd, input logic [7:0] zd);
        M68K_DATA = wd;
        SDD_IN = zd;
        drive(m);
        for (int i = 1; i < LAT; i++) tick_chk();
        tick();
        model_apply(m, cyc);
        chk_all(tag);
        drive(7'b0);
        idle(3);
    endtask

    logic [6:0] mask_tab [12];

    initial begin
        mask_tab[0]  = M_WR;
        mask_tab[1]  = M_WR;
        mask_tab[2]  = M_RD;
        mask_tab[3]  = M_ZR;
        mask_tab[4]  = M_ZW;
        mask_tab[5]  = M_CLR;
        mask_tab[6]  = M_EN;
        mask_tab[7]  = M_DIS;
        mask_tab[8]  = M_WR | M_CLR;
        mask_tab[9]  = M_ZW | M_RD;
        mask_tab[10] = M_EN | M_DIS;
        mask_tab[11] = M_WR | M_DIS;

        model_reset();
        drive(7'b0);
        rst = 1'b1;
        tick();
        tick();
        chk_all("reset");
        rst = 1'b0;
        idle(2);

        // Enabled NMI, command, held until clear
        strobe("en", M_EN, 8'h00, 8'h00);
        strobe("wr03", M_WR, 8'h03, 8'h00);
        idle(35);
        chk("nmi_wait_low", {7'b0, nZ80NMI}, 8'h00);
        strobe("clr", M_CLR, 8'h00, 8'h00);
        chk("nmi_released", {7'b0, nZ80NMI}, 8'h01);

        // Disabled NMI; enabling with a pending command stays quiet
        strobe("dis", M_DIS, 8'h00, 8'h00);
        strobe("wr7f", M_WR, 8'h7f, 8'h00);
        strobe("en_pend", M_EN, 8'h00, 8'h00);
        idle(30);
        chk("nmi_no_raise", {7'b0, nZ80NMI}, 8'h01);
        strobe("clr2", M_CLR, 8'h00, 8'h00);

        // Reply path
        strobe("zw_c3", M_ZW, 8'h00, 8'hc3);
        strobe("rd68", M_RD, 8'h00, 8'h00);
        chk("reply_kept", SND_REPLY, 8'hc3);

        // Back-to-back writes and overrun
        strobe("wr01", M_WR, 8'h01, 8'h00);
        strobe("wr02", M_WR, 8'h02, 8'h00);
        chk("last_wins", SDD_OUT, 8'h02);
        strobe("clr_ovr", M_CLR, 8'h00, 8'h00);
        chk("ovr_cleared", {7'b0, OVERRUN}, 8'h00);
        idle(30);

        // Write+clear in one cycle restarts the pulse
        strobe("wr_a5", M_WR, 8'ha5, 8'h00);
        idle(8);
        strobe("wr_clr", M_WR | M_CLR, 8'h5a, 8'h00);
        strobe("clr3", M_CLR, 8'h00, 8'h00);
        chk("nmi_restarted", {7'b0, nZ80NMI}, 8'h00);
        idle(30);
        strobe("en_dis", M_EN | M_DIS, 8'h00, 8'h00);
        strobe("wr_noen", M_WR, 8'h11, 8'h00);
        idle(30);
        strobe("clr4", M_CLR, 8'h00, 8'h00);

        // Reset in the middle of a pulse
        strobe("en2", M_EN, 8'h00, 8'h00);
        strobe("wr_rst", M_WR, 8'h99, 8'h66);
        strobe("zw_rst", M_ZW, 8'h00, 8'h66);
        idle(3);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst");
        tick();
        rst = 1'b0;
        idle(3);
        strobe("wr55", M_WR, 8'h55, 8'h00);
        idle(5);
        strobe("clr5", M_CLR, 8'h00, 8'h00);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            strobe("rand", mask_tab[$urandom_range(11, 0)],
                   8'($urandom), 8'($urandom));
            idle($urandom_range(30, 0));
        end
        idle(40);
        chk_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neo_sndlatch.md
Name: neo_sndlatch

Overview:
- 68k↔Z80 sound mailbox: the responder end of the sound-CPU interface, driven by the Z80 decode strobes (nSDZ80R/nSDZ80W/nSDZ80CLR) generated in the Z80 controller.
- 68k writes a command byte (REG_SOUND). Block latches it, raises Z80 NMI when enabled, and holds it until the Z80 reads and clears it.
- Z80 writes a reply byte that the 68k reads back.
- All strobes are asynchronous to CLK_24M and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each strobe synchroniser (min 2).
- NMI_MIN_CYCLES, 24, minimum nZ80NMI low time in CLK_24M cycles (1 µs).

Ports:
- CLK_24M  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- nSNDWR  in  1  68k command write strobe, active low.
- nSNDRD  in  1  68k reply read strobe, active low.
- M68K_DATA  in  8  68k data, stable while nSNDWR low.
- SND_REPLY  out  8  reply byte presented to the 68k.
- nSDZ80R  in  1  Z80 command read strobe, active low.
- nSDZ80W  in  1  Z80 reply write strobe, active low.
- nSDZ80CLR  in  1  Z80 command clear/NMI ack, active low.
- nNMIEN  in  1  Z80 NMI enable write strobe, active low.
- nNMIDIS  in  1  Z80 NMI disable write strobe, active low.
- SDD_IN  in  8  Z80 data bus in.
- SDD_OUT  out  8  latched command byte presented to the Z80.
- nZ80NMI  out  1  Z80 NMI, active low.
- CMD_PENDING  out  1  command written, not yet cleared.
- REPLY_VALID  out  1  reply written, not yet read by 68k.
- OVERRUN  out  1  see Optional Feature.

Behaviour:
- Reset (async, any state): SDD_OUT=0, SND_REPLY=0, nZ80NMI=1, CMD_PENDING=0, REPLY_VALID=0, OVERRUN=0, NMI enable=0, FSM=IDLE, synchronisers=1.
- Strobe handling:
  - Each strobe passes through SYNC_STAGES FFs, then a falling-edge detector: one-cycle event per assertion.
  - Data buses are sampled on the event cycle. Total latency from pin edge to register update is SYNC_STAGES+1 cycles.
- Command write event: SDD_OUT<=M68K_DATA[7:0], CMD_PENDING<=1. If NMI enable=1, FSM → PULSE.
- Clear event: CMD_PENDING<=0.
- Z80 read event: no state change; SDD_OUT is driven continuously.
- Reply write event: SND_REPLY<=SDD_IN, REPLY_VALID<=1.
- 68k read event: REPLY_VALID<=0. SND_REPLY is retained.
- NMI enable/disable: nNMIEN event sets enable, nNMIDIS event clears it. If both fire in the same cycle, disable wins.
- Enabling while CMD_PENDING=1 does not raise NMI. Only a fresh command write does.
- NMI FSM:
  - IDLE: nZ80NMI=1.
  - PULSE: nZ80NMI=0, 8-bit counter counts NMI_MIN_CYCLES. At terminal count → WAIT.
  - WAIT: nZ80NMI=0 until CMD_PENDING=0, then → IDLE.
  - Clear event during PULSE: CMD_PENDING drops, but the FSM stays in PULSE. NMI releases at minimum width, passing through WAIT for 1 cycle.
  - Disable event in PULSE/WAIT: → IDLE immediately, nZ80NMI=1.
- Simultaneous events, same cycle:
  - Command write + clear: write wins, CMD_PENDING=1. NMI restarts (counter reloads) if enabled.
  - Command write while in PULSE/WAIT: counter reloads, FSM → PULSE.
  - Reply write + 68k read: write wins, REPLY_VALID=1.
- Back-to-back 68k writes overwrite SDD_OUT. The last value wins.

Optional Feature:
- Macro: SNDLATCH_OVERRUN_EN.
- Enabled: OVERRUN is set sticky when a command write event occurs with CMD_PENDING=1. It is cleared on a clear event, unless a write is in the same cycle.
- Disabled: OVERRUN is tied to 0 and no overrun logic exists.

Test Plan:
- Reset mid-PULSE (RESET=1 at cycle 10 of NMI) → nZ80NMI=1 and all outputs 0 within the same cycle. After release, a write of 0x55 behaves normally.
- Enable NMI, 68k writes 0x03 → SDD_OUT=0x03, CMD_PENDING=1 at cycle 3. nZ80NMI low ≥24 cycles and held until nSDZ80CLR, released 1 cycle after the clear event.
- NMI disabled, write 0x7F → CMD_PENDING=1, nZ80NMI stays 1. Then nNMIEN alone → still no NMI.
- Z80 writes 0xC3 via nSDZ80W → SND_REPLY=0xC3, REPLY_VALID=1. nSNDRD → REPLY_VALID=0, SND_REPLY still 0xC3.
- Write 0x01 then 0x02 without clear → SDD_OUT=0x02. OVERRUN=1 with the macro, 0 without. nSDZ80CLR → OVERRUN=0.
- Write and clear events in the same cycle → CMD_PENDING=1, NMI counter restarts. nNMIEN and nNMIDIS together → enable=0.
